// File: rtl/alu_pkg.sv
// Shared definitions for the alu_pipe block.
//   alu_op_e    : 4-bit opcode map (LSL/LSR distinct codes)
//   alu_state_e : control FSM encoding; StDiv exists only when ALU_DIV_EN is defined
// Configuration macro: ALU_DIV_EN (iterative divider present when defined).
package alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpMul  = 4'd2,
    OpDiv  = 4'd3,
    OpLsl  = 4'd4,
    OpLsr  = 4'd5,
    OpAddi = 4'd6,
    OpSubi = 4'd7,
    OpAndi = 4'd8,
    OpLand = 4'd9,
    OpLor  = 4'd10,
    OpXor  = 4'd11,
    OpEq   = 4'd12,
    OpNe   = 4'd13,
    OpLtu  = 4'd14,
    OpGtu  = 4'd15
  } alu_op_e;

`ifdef ALU_DIV_EN
  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StDiv  = 1'b1
  } alu_state_e;
`else
  typedef enum logic [0:0] {
    StIdle = 1'b0
  } alu_state_e;
`endif

endpackage

// File: rtl/alu_div_iter.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
//   clk, rst  : clock, asynchronous active-high reset (aborts a running division)
//   start     : load dividend/divisor and begin (divisor must be non-zero)
//   dividend  : W-bit numerator
//   divisor   : W-bit denominator
//   busy      : iteration in progress
//   done      : one-cycle pulse, quotient valid, W cycles after start
//   quotient  : W-bit unsigned quotient
module alu_div_iter #(
  parameter int unsigned W = 72
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int unsigned CntW = $clog2(W + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

  logic [W-1:0]    quo_q, quo_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    dsr_q, dsr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W:0]      trial;

  // Quotient register doubles as the dividend shift register: its MSB feeds the remainder.
  always_comb begin
    trial  = {rem_q, quo_q[W-1]} - {1'b0, dsr_q};
    quo_d  = quo_q;
    rem_d  = rem_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      quo_d  = dividend;
      rem_d  = '0;
      dsr_d  = divisor;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // trial[W] set means the shifted remainder was smaller than the divisor: restore.
      if (!trial[W]) begin
        rem_d = trial[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = {rem_q[W-2:0], quo_q[W-1]};
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q + CntW'(1);
      if (cnt_q == LastCnt) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked W-bit ALU with registered result and zero/carry/err flags.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operation handshake (op, a, b)
//   op                  : 4-bit opcode (alu_pkg::alu_op_e)
//   a, b                : W-bit unsigned operands; b[IMM_W-1:0] is the immediate for *I ops
//   out_valid/out_ready : result handshake; c/zero/carry/err held while stalled
//   c                   : W-bit result
//   zero                : c == 0
//   carry               : carry-out of ADD/ADDI, borrow of SUB/SUBI
//   err                 : divide-by-zero, or any DIV when the divider is absent
// Configuration macro: ALU_DIV_EN. Defined: DIV runs on alu_div_iter (latency W+1).
// Undefined: no divider, DIV returns c=0, err=1 with latency 1.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned W     = 72,
  parameter int unsigned IMM_W = 55
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] op,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    c,
  output logic            zero,
  output logic            carry,
  output logic            err
);

  localparam logic [W-1:0] WidthVal = W'(W);

  alu_op_e    op_e;
  alu_state_e state_q, state_d;

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] c_q, c_d;
  logic         zero_q, zero_d;
  logic         carry_q, carry_d;
  logic         err_q, err_d;

  logic         accept;
  logic [W-1:0] imm;
  logic [W:0]   add_full, sub_full, addi_full, subi_full;
  logic [W-1:0] mul_res;
  logic         shamt_big;
  logic [W-1:0] res_c;
  logic         res_carry, res_err;

  logic         load;
  logic [W-1:0] ld_c;
  logic         ld_carry, ld_err;

  assign op_e = alu_op_e'(op);

  // ---------------------------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------------------------
  assign imm       = W'(b[IMM_W-1:0]);
  // Bit W of each widened sum is the carry; of each widened difference, the borrow.
  assign add_full  = {1'b0, a} + {1'b0, b};
  assign sub_full  = {1'b0, a} - {1'b0, b};
  assign addi_full = {1'b0, a} + {1'b0, imm};
  assign subi_full = {1'b0, a} - {1'b0, imm};
  assign mul_res   = a * b;
  assign shamt_big = (b >= WidthVal);

  always_comb begin
    res_c     = '0;
    res_carry = 1'b0;
    res_err   = 1'b0;
    unique case (op_e)
      OpAdd: begin
        res_c     = add_full[W-1:0];
        res_carry = add_full[W];
      end
      OpSub: begin
        res_c     = sub_full[W-1:0];
        res_carry = sub_full[W];
      end
      OpMul: res_c = mul_res;
      OpDiv: begin
        // Only reached for b==0 when the divider exists; otherwise every DIV lands here.
`ifdef ALU_DIV_EN
        res_c = '1;
`else
        res_c = '0;
`endif
        res_err = 1'b1;
      end
      OpLsl: res_c = shamt_big ? '0 : (a << b);
      OpLsr: res_c = shamt_big ? '0 : (a >> b);
      OpAddi: begin
        res_c     = addi_full[W-1:0];
        res_carry = addi_full[W];
      end
      OpSubi: begin
        res_c     = subi_full[W-1:0];
        res_carry = subi_full[W];
      end
      OpAndi: res_c = a & imm;
      OpLand: res_c = {{(W-1){1'b0}}, (a != '0) && (b != '0)};
      OpLor:  res_c = {{(W-1){1'b0}}, (a != '0) || (b != '0)};
      OpXor:  res_c = a ^ b;
      OpEq:   res_c = {{(W-1){1'b0}}, a == b};
      OpNe:   res_c = {{(W-1){1'b0}}, a != b};
      OpLtu:  res_c = {{(W-1){1'b0}}, a < b};
      OpGtu:  res_c = {{(W-1){1'b0}}, a > b};
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Optional iterative divider
  // ---------------------------------------------------------------------------------------------
`ifdef ALU_DIV_EN
  logic         div_go;
  logic         div_busy;
  logic         div_done;
  logic [W-1:0] div_quo;

  assign div_go = accept && (op_e == OpDiv) && (b != '0);

  alu_div_iter #(
    .W(W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_go),
    .dividend (a),
    .divisor  (b),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  assign in_ready = !rst && (state_q == StIdle) && !div_busy && (!out_valid_q || out_ready);
`else
  assign in_ready = !rst && (state_q == StIdle) && (!out_valid_q || out_ready);
`endif

  assign accept = in_valid && in_ready;

  // ---------------------------------------------------------------------------------------------
  // Control FSM and output register
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    c_d         = c_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    err_d       = err_q;
    load        = 1'b0;
    ld_c        = res_c;
    ld_carry    = res_carry;
    ld_err      = res_err;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
`ifdef ALU_DIV_EN
          if (div_go) begin
            state_d = StDiv;
          end else begin
            load = 1'b1;
          end
`else
          load = 1'b1;
`endif
        end
      end
`ifdef ALU_DIV_EN
      StDiv: begin
        // out_valid was drained when the DIV was accepted, so this load never clobbers a result.
        if (div_done) begin
          load     = 1'b1;
          ld_c     = div_quo;
          ld_carry = 1'b0;
          ld_err   = 1'b0;
          state_d  = StIdle;
        end
      end
`endif
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      c_d         = ld_c;
      zero_d      = (ld_c == '0);
      carry_d     = ld_carry;
      err_d       = ld_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: the stimulus side pushes model results, a negedge monitor
// pops and compares on every output transfer and also checks latency, hold and ready gating.
module tb_alu_pipe;

  localparam int W     = 72;
  localparam int IMM_W = 55;

  typedef struct {
    logic [W-1:0] c;
    logic         zero;
    logic         carry;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] c;
  logic         zero, carry, err;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  bit   rand_rdy = 1'b0;
  exp_t sb[$];

  alu_pipe #(
    .W     (W),
    .IMM_W (IMM_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .zero      (zero),
    .carry     (carry),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input bit ok, input string name, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h, need %h (t=%0t)", name, act, req, $time);
  endtask

  // Reference model straight from the opcode table, using plain unsigned arithmetic.
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t         e;
    logic [W-1:0] im;
    logic [W-1:0] ones;
    ones    = '1;
    im      = '0;
    im[IMM_W-1:0] = y[IMM_W-1:0];
    e.c     = '0;
    e.carry = 1'b0;
    e.err   = 1'b0;
    e.lat   = 1;
    e.acc   = 0;
    case (o)
      4'd0:  begin e.c = x + y;  e.carry = (x > ones - y); end
      4'd1:  begin e.c = x - y;  e.carry = (x < y); end
      4'd2:  e.c = W'((2*W)'(x) * (2*W)'(y));
      4'd3: begin
`ifdef ALU_DIV_EN
        if (y == 0) begin e.c = ones; e.err = 1'b1; end
        else begin e.c = x / y; e.lat = W + 1; end
`else
        e.c = '0; e.err = 1'b1;
`endif
      end
      4'd4:  e.c = (y >= W) ? '0 : x << y;
      4'd5:  e.c = (y >= W) ? '0 : x >> y;
      4'd6:  begin e.c = x + im; e.carry = (x > ones - im); end
      4'd7:  begin e.c = x - im; e.carry = (x < im); end
      4'd8:  e.c = x & im;
      4'd9:  e.c = (x != 0 && y != 0) ? 1 : 0;
      4'd10: e.c = (x != 0 || y != 0) ? 1 : 0;
      4'd11: e.c = x ^ y;
      4'd12: e.c = (x == y) ? 1 : 0;
      4'd13: e.c = (x != y) ? 1 : 0;
      4'd14: e.c = (x < y) ? 1 : 0;
      default: e.c = (x > y) ? 1 : 0;
    endcase
    e.zero = (e.c == 0);
    return e;
  endfunction

  // Monitor: pops the scoreboard on output transfers and checks timing properties.
  bit           seen      = 1'b0;
  bit           prev_stall = 1'b0;
  bit           div_pend  = 1'b0;
  logic [W-1:0] prev_c;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      seen       = 1'b0;
      prev_stall = 1'b0;
      div_pend   = 1'b0;
    end else begin
      if (prev_stall) chk(out_valid && (c == prev_c), "hold_under_stall", c, prev_c);
      if (out_valid && !seen) begin
        if (sb.size() == 0) begin
          chk(1'b0, "spurious_out_valid", W'(out_valid), '0);
        end else begin
          chk((cyc - sb[0].acc) == sb[0].lat, "latency", W'(cyc - sb[0].acc), W'(sb[0].lat));
        end
        seen     = 1'b1;
        div_pend = 1'b0;
      end
      if (div_pend) chk(!in_ready, "in_ready_during_div", W'(in_ready), '0);
      if (out_valid && !out_ready) chk(!in_ready, "in_ready_while_stalled", W'(in_ready), '0);
      if (out_valid && out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk(c == e.c, "result_c", c, e.c);
        chk({zero, carry, err} == {e.zero, e.carry, e.err}, "flags_zce",
            W'({zero, carry, err}), W'({e.zero, e.carry, e.err}));
        seen = 1'b0;
      end
      if (in_valid && in_ready) begin
        e     = model(op, a, b);
        e.acc = cyc;
        sb.push_back(e);
        if (e.lat > 1) div_pend = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_c     = c;
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int waited;
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 300) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) chk(1'b0, "send_timeout", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] x, y;
    int           t0;
    ones      = '1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = '0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk(!in_ready, "reset_in_ready", W'(in_ready), '0);
    chk(!out_valid, "reset_out_valid", W'(out_valid), '0);
    chk(c == '0, "reset_c", c, '0);
    chk({zero, carry, err} == 3'b000, "reset_flags", W'({zero, carry, err}), '0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk(in_ready, "ready_after_reset", W'(in_ready), W'(1));
    @(posedge clk);
    #1;

    // Directed corner cases.
    send(4'd0, ones, 72'd1);
    send(4'd1, 72'd3, 72'd5);
    send(4'd4, 72'd1, 72'd71);
    send(4'd5, 72'd5, 72'd72);
    send(4'd3, 72'd100, 72'd7);
    send(4'd3, 72'd55, 72'd0);
    send(4'd8, ones, ones);
    send(4'd12, 72'd42, 72'd42);
    send(4'd15, 72'd1, 72'd2);
    send(4'd9, 72'd0, 72'd9);
    send(4'd7, 72'd0, ones);

    // Full throughput: eight ADDs in eight cycles.
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(4'd0, W'(i * 1000), W'(i + 3));
    chk((cyc - t0) == 8, "throughput_cycles", W'(cyc - t0), W'(8));

    // Backpressure: result held three cycles, second op waits.
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    send(4'd0, 72'd10, 72'd20);
    fork
      send(4'd2, 72'd12345, 72'd678);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Reset during DIV iteration 10 (or while a result is held when no divider exists).
    out_ready = 1'b0;
    send(4'd3, 72'd100, 72'd7);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk(!out_valid, "midreset_out_valid", W'(out_valid), '0);
    chk(c == '0, "midreset_c", c, '0);
    chk(!err && !in_ready, "midreset_err_ready", W'({err, in_ready}), '0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    send(4'd0, 72'd5, 72'd6);
    send(4'd3, 72'd1000, 72'd10);

    // Randomized ops with random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: begin x = rnd_w(); y = rnd_w(); end
        1: begin x = W'($urandom_range(0, 255)); y = W'($urandom_range(0, 255)); end
        2: begin x = ($urandom_range(0, 1) != 0) ? ones : '0; y = rnd_w(); end
        default: begin x = rnd_w(); y = W'($urandom_range(0, 80)); end
      endcase
      send(4'($urandom_range(0, 15)), x, y);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    chk(sb.size() == 0, "scoreboard_drained", W'(sb.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
